// File: rtl/core101_pkg.sv
// Shared core definitions: default datapath widths, ALU opcode constants and
// the issue-sequencer state encoding.
package core101_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RF_AW_DEF = 5;
  localparam int OPC_W_DEF = 4;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLL = 4'h5;
  localparam logic [3:0] ALU_SRL = 4'h6;
  localparam logic [3:0] ALU_SRA = 4'h7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_issue_seq_if.sv
// Decode-op handshake, ALU operand/result and writeback signals of the issue
// sequencer; slave is the sequencer side, master is the decode/ALU side.
interface alu_issue_seq_if
  import core101_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RF_AW = RF_AW_DEF,
  parameter int OPC_W = OPC_W_DEF
);

  logic             op_valid;
  logic             op_ready;
  logic [OPC_W-1:0] op_opcode;
  logic [RF_AW-1:0] op_rs1;
  logic [RF_AW-1:0] op_rs2;
  logic [RF_AW-1:0] op_rd;
  logic [XLEN-1:0]  op_imm;
  logic             op_use_imm;

  logic [XLEN-1:0]  alu_operand_a;
  logic [XLEN-1:0]  alu_operand_b;
  logic [OPC_W-1:0] alu_opcode;
  logic [XLEN-1:0]  alu_result;

  logic             wb_valid;
  logic [RF_AW-1:0] wb_rd;
  logic [XLEN-1:0]  wb_data;

  modport slave (
    input  op_valid, op_opcode, op_rs1, op_rs2, op_rd, op_imm, op_use_imm,
    input  alu_result,
    output op_ready, alu_operand_a, alu_operand_b, alu_opcode,
    output wb_valid, wb_rd, wb_data
  );

  modport master (
    output op_valid, op_opcode, op_rs1, op_rs2, op_rd, op_imm, op_use_imm,
    output alu_result,
    input  op_ready, alu_operand_a, alu_operand_b, alu_opcode,
    input  wb_valid, wb_rd, wb_data
  );

endinterface

// File: rtl/alu_issue_seq_reg_file.sv
// Register file: two combinational read ports, one synchronous write port,
// x0 hardwired to zero, every entry cleared by the asynchronous reset.
module reg_file
  import core101_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RF_AW = RF_AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RF_AW-1:0] rd_addr_a,
  output logic [XLEN-1:0]  rd_dat_a,
  input  logic [RF_AW-1:0] rd_addr_b,
  output logic [XLEN-1:0]  rd_dat_b,
  input  logic             wr_vld,
  input  logic [RF_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]  wr_dat
);

  localparam int DEPTH = 2 ** RF_AW;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    // Writes to x0 are dropped so that entry stays at its reset value.
    if (wr_vld && (wr_addr != '0)) begin
      mem_d[wr_addr] = wr_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_dat_a = (rd_addr_a == '0) ? '0 : mem_q[rd_addr_a];
  assign rd_dat_b = (rd_addr_b == '0) ? '0 : mem_q[rd_addr_b];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer between decode and ALU: IDLE -> READ -> EXEC -> WB.
// Optional ALU_ISSUE_PERF_CNT_EN adds perf_retired, a wrapping count of writebacks.
module alu_issue_seq
  import core101_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RF_AW = RF_AW_DEF,
  parameter int OPC_W = OPC_W_DEF
) (
  input  logic          CLOCK_50,
  input  logic          RESET,
  alu_issue_seq_if.slave io
`ifdef ALU_ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]   perf_retired
`endif
);

  seq_state_e       state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [RF_AW-1:0] rs1_q, rs1_d;
  logic [RF_AW-1:0] rs2_q, rs2_d;
  logic [RF_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic             use_imm_q, use_imm_d;
  logic [XLEN-1:0]  alu_a_q, alu_a_d;
  logic [XLEN-1:0]  alu_b_q, alu_b_d;
  logic [OPC_W-1:0] alu_opc_q, alu_opc_d;
  logic             wb_vld_q, wb_vld_d;
  logic [RF_AW-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_dat_q, wb_dat_d;

  logic             op_rdy;
  logic             accept;
  logic             rf_wr_vld;
  logic [XLEN-1:0]  rf_dat_a;
  logic [XLEN-1:0]  rf_dat_b;

  assign op_rdy = (state_q == IDLE) || (state_q == WB);
  assign accept = io.op_valid && op_rdy;

  reg_file #(
    .XLEN  (XLEN),
    .RF_AW (RF_AW)
  ) u_reg_file (
    .clk       (CLOCK_50),
    .rst       (RESET),
    .rd_addr_a (rs1_q),
    .rd_dat_a  (rf_dat_a),
    .rd_addr_b (rs2_q),
    .rd_dat_b  (rf_dat_b),
    .wr_vld    (rf_wr_vld),
    .wr_addr   (rd_q),
    .wr_dat    (io.alu_result)
  );

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    use_imm_d = use_imm_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_opc_d = alu_opc_q;
    wb_vld_d  = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_dat_d  = wb_dat_q;
    rf_wr_vld = 1'b0;

    // ALU inputs only change at the READ->EXEC edge so the ALU sees stable
    // operands through EXEC and holds them in IDLE/WB.
    case (state_q)
      IDLE, WB: begin
        if (accept) begin
          opc_d     = io.op_opcode;
          rs1_d     = io.op_rs1;
          rs2_d     = io.op_rs2;
          rd_d      = io.op_rd;
          imm_d     = io.op_imm;
          use_imm_d = io.op_use_imm;
          state_d   = READ;
        end else begin
          state_d   = IDLE;
        end
      end
      READ: begin
        alu_a_d   = rf_dat_a;
        alu_b_d   = use_imm_q ? imm_q : rf_dat_b;
        alu_opc_d = opc_q;
        state_d   = EXEC;
      end
      EXEC: begin
        rf_wr_vld = 1'b1;
        wb_vld_d  = 1'b1;
        wb_rd_d   = rd_q;
        wb_dat_d  = io.alu_result;
        state_d   = WB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      opc_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_opc_q <= '0;
      wb_vld_q  <= 1'b0;
      wb_rd_q   <= '0;
      wb_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      use_imm_q <= use_imm_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_opc_q <= alu_opc_d;
      wb_vld_q  <= wb_vld_d;
      wb_rd_q   <= wb_rd_d;
      wb_dat_q  <= wb_dat_d;
    end
  end

  assign io.op_ready      = op_rdy;
  assign io.alu_operand_a = alu_a_q;
  assign io.alu_operand_b = alu_b_q;
  assign io.alu_opcode    = alu_opc_q;
  assign io.wb_valid      = wb_vld_q;
  assign io.wb_rd         = wb_rd_q;
  assign io.wb_data       = wb_dat_q;

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Counts on the same edge that raises wb_valid; wraps naturally.
  always_comb begin
    perf_d = perf_q;
    if (wb_vld_d) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_retired = perf_q;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: transaction-level model plus per-cycle compare,
// with directed ops and literal expectations; covers ALU_ISSUE_PERF_CNT_EN when defined.
module tb_alu_issue_seq;
  import core101_pkg::*;

  localparam int XLEN  = 32;
  localparam int RF_AW = 5;
  localparam int OPC_W = 4;

  logic CLOCK_50 = 1'b0;
  logic RESET    = 1'b1;
  always #5 CLOCK_50 = ~CLOCK_50;

  alu_issue_seq_if #(.XLEN(XLEN), .RF_AW(RF_AW), .OPC_W(OPC_W)) io ();

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [31:0] perf_retired;
`endif

  alu_issue_seq #(.XLEN(XLEN), .RF_AW(RF_AW), .OPC_W(OPC_W)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .io       (io)
`ifdef ALU_ISSUE_PERF_CNT_EN
    ,
    .perf_retired (perf_retired)
`endif
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  // Combinational ALU in the environment.
  assign io.alu_result = alu_f(io.alu_operand_a, io.alu_operand_b, io.alu_opcode);

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Model: m_age counts edges since an op was accepted (3 = nothing in flight).
  logic [31:0] m_rf [32];
  int          m_age = 3;
  logic [3:0]  m_opc = '0;
  logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  logic [31:0] m_imm = '0;
  logic        m_use = 1'b0;
  logic [31:0] e_a = '0, e_b = '0, e_wbd = '0;
  logic [3:0]  e_opc = '0;
  logic        e_wbv = 1'b0;
  logic [4:0]  e_wbrd = '0;
  logic [31:0] m_perf = '0;
  logic [31:0] perf_bias = '0;
  wire         m_ready = (m_age >= 2);

  always @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) m_rf[i] <= '0;
      m_age  <= 3;
      m_opc  <= '0; m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_imm <= '0; m_use <= 1'b0;
      e_a    <= '0; e_b <= '0; e_opc <= '0;
      e_wbv  <= 1'b0; e_wbrd <= '0; e_wbd <= '0;
      m_perf <= '0;
    end else begin
      e_wbv <= 1'b0;
      if (m_age == 0) begin
        e_a   <= m_rf[m_rs1];
        e_b   <= m_use ? m_imm : m_rf[m_rs2];
        e_opc <= m_opc;
        m_age <= 1;
      end else if (m_age == 1) begin
        if (m_rd != 0) m_rf[m_rd] <= alu_f(e_a, e_b, e_opc);
        e_wbv  <= 1'b1;
        e_wbrd <= m_rd;
        e_wbd  <= alu_f(e_a, e_b, e_opc);
        m_perf <= m_perf + 32'd1;
        m_age  <= 2;
      end else if (io.op_valid) begin
        m_opc <= io.op_opcode; m_rs1 <= io.op_rs1; m_rs2 <= io.op_rs2;
        m_rd  <= io.op_rd;     m_imm <= io.op_imm; m_use <= io.op_use_imm;
        m_age <= 0;
      end else begin
        m_age <= 3;
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      chk("op_ready",   32'(io.op_ready),   32'(m_ready));
      chk("wb_valid",   32'(io.wb_valid),   32'(e_wbv));
      chk("wb_rd",      32'(io.wb_rd),      32'(e_wbrd));
      chk("wb_data",    io.wb_data,         e_wbd);
      chk("alu_a",      io.alu_operand_a,   e_a);
      chk("alu_b",      io.alu_operand_b,   e_b);
      chk("alu_opcode", 32'(io.alu_opcode), 32'(e_opc));
`ifdef ALU_ISSUE_PERF_CNT_EN
      chk("perf_retired", perf_retired, m_perf + perf_bias);
`endif
    end
  end

  // Offers an op at the first negedge where the sequencer is expected ready;
  // returns 1ns after the accepting edge.
  task automatic issue(input logic [3:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic use_imm);
    int guard = 0;
    @(negedge CLOCK_50);
    while (!m_ready && guard < 20) begin
      @(negedge CLOCK_50);
      guard++;
    end
    if (guard >= 20) chk("issue_wait_ready", 32'(io.op_ready), 32'd1);
    io.op_opcode  = opc;
    io.op_rd      = rd;
    io.op_rs1     = rs1;
    io.op_rs2     = rs2;
    io.op_imm     = imm;
    io.op_use_imm = use_imm;
    io.op_valid   = 1'b1;
    @(posedge CLOCK_50);
    #1 io.op_valid = 1'b0;
  endtask

  int t1;

  initial begin
    io.op_valid = 1'b0; io.op_opcode = '0; io.op_rs1 = '0; io.op_rs2 = '0;
    io.op_rd = '0; io.op_imm = '0; io.op_use_imm = 1'b0;
    RESET = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET  = 1'b0;
    chk_en = 1'b1;

    // Idle after reset
    repeat (5) @(posedge CLOCK_50);
    #1;
    chk("idle_op_ready", 32'(io.op_ready), 32'd1);
    chk("idle_wb_valid", 32'(io.wb_valid), 32'd0);
    chk("idle_alu_a",    io.alu_operand_a, 32'd0);
    chk("idle_alu_b",    io.alu_operand_b, 32'd0);

    // ADD x1 = x0 + 5
    issue(ALU_ADD, 5'd1, 5'd0, 5'd0, 32'h0000_0005, 1'b1);
    chk("add_ready_low", 32'(io.op_ready), 32'd0);
    @(posedge CLOCK_50); #1;
    chk("add_imm_b",     io.alu_operand_b, 32'd5);
    chk("add_wbv_early", 32'(io.wb_valid), 32'd0);
    @(posedge CLOCK_50); #1;
    chk("add_wbv",  32'(io.wb_valid), 32'd1);
    chk("add_wbrd", 32'(io.wb_rd),    32'd1);
    chk("add_wbd",  io.wb_data,       32'd5);

    // Back-to-back: SUB x2 = x1 - 3, then ADD x3 = x2 + x1 offered in WB
    issue(ALU_SUB, 5'd2, 5'd1, 5'd0, 32'd3, 1'b1);
    repeat (2) @(posedge CLOCK_50); #1;
    chk("sub_wbd", io.wb_data, 32'd2);
    t1 = cyc;
    issue(ALU_ADD, 5'd3, 5'd2, 5'd1, 32'd0, 1'b0);
    repeat (2) @(posedge CLOCK_50); #1;
    chk("b2b_wbd",     io.wb_data,       32'd7);
    chk("b2b_wbv",     32'(io.wb_valid), 32'd1);
    chk("b2b_spacing", 32'(cyc - t1),    32'd3);

    // rd = x0: writeback pulses, write dropped
    issue(ALU_ADD, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
    repeat (2) @(posedge CLOCK_50); #1;
    chk("x0_wbv",  32'(io.wb_valid), 32'd1);
    chk("x0_wbrd", 32'(io.wb_rd),    32'd0);
    chk("x0_wbd",  io.wb_data,       32'hFFFF_FFFF);
    issue(ALU_ADD, 5'd4, 5'd0, 5'd0, 32'd0, 1'b0);
    @(posedge CLOCK_50); #1;
    chk("x0_read_a", io.alu_operand_a, 32'd0);
    chk("x0_read_b", io.alu_operand_b, 32'd0);
    repeat (2) @(posedge CLOCK_50);

    // Reset while in EXEC aborts the op
    issue(ALU_ADD, 5'd5, 5'd3, 5'd0, 32'd1, 1'b1);
    @(posedge CLOCK_50); #2;
    RESET = 1'b1;
    #1;
    chk("rst_wbv",   32'(io.wb_valid),   32'd0);
    chk("rst_ready", 32'(io.op_ready),   32'd1);
    chk("rst_alu_a", io.alu_operand_a,   32'd0);
    @(negedge CLOCK_50); #1;
    RESET = 1'b0;
    @(posedge CLOCK_50); #1;
    chk("post_rst_ready", 32'(io.op_ready), 32'd1);
    chk("post_rst_wbv",   32'(io.wb_valid), 32'd0);
    repeat (3) @(posedge CLOCK_50);
    issue(ALU_ADD, 5'd6, 5'd5, 5'd3, 32'd0, 1'b0);
    @(posedge CLOCK_50); #1;
    chk("post_rst_rf5", io.alu_operand_a, 32'd0);
    chk("post_rst_rf3", io.alu_operand_b, 32'd0);

    // XOR / SRA / register-register SUB
    issue(ALU_XOR, 5'd7, 5'd0, 5'd0, 32'hA5A5_0000, 1'b1);
    issue(ALU_SRA, 5'd8, 5'd7, 5'd0, 32'd4, 1'b1);
    repeat (2) @(posedge CLOCK_50); #1;
    chk("sra_wbd", io.wb_data, 32'hFA5A_5000);
    issue(ALU_SUB, 5'd9, 5'd0, 5'd8, 32'd0, 1'b0);
    repeat (2) @(posedge CLOCK_50); #1;
    chk("subrr_wbd", io.wb_data, 32'h05A5_B000);
    repeat (2) @(posedge CLOCK_50);

`ifdef ALU_ISSUE_PERF_CNT_EN
    @(negedge CLOCK_50); #1;
    RESET = 1'b1;
    #3 RESET = 1'b0;
    for (int k = 0; k < 4; k++) issue(ALU_ADD, 5'd1, 5'd1, 5'd0, 32'd1, 1'b1);
    repeat (2) @(posedge CLOCK_50); #1;
    chk("perf_four", perf_retired, 32'd4);
    @(negedge CLOCK_50); #2;
    force dut.perf_q = 32'hFFFF_FFFF;
    perf_bias = 32'hFFFF_FFFF - m_perf;
    #1 release dut.perf_q;
    issue(ALU_ADD, 5'd1, 5'd1, 5'd0, 32'd1, 1'b1);
    repeat (2) @(posedge CLOCK_50); #1;
    chk("perf_wrap", perf_retired, 32'd0);
`endif

    repeat (4) @(posedge CLOCK_50);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
